fcc_way_arbiter: RTL and testbench

FCC_WAY_ARBITER -- requirements
Module: fcc_way_arbiter

---
 rtl/fcc_way_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_fcc_way_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fcc_way_arbiter.sv
// fcc_way_arbiter: shares one fcc_executer among WAY_NUM fcc_scheduler ways.
// Round-robin grant in IDLE, command held in ISSUE until the executer drops ready,
// completion in FIN when ready returns. A watchdog aborts a command the executer never takes.
module fcc_way_arbiter #(
   parameter int WAY_NUM = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                   usr_clk,
   input  logic                   usr_rst,
   input  logic [WAY_NUM-1:0]     i_req_valid,
   output logic [WAY_NUM-1:0]     o_req_ready,
   input  logic [16*WAY_NUM-1:0]  i_req_cmd,
   input  logic [16*WAY_NUM-1:0]  i_req_cmd_id,
   input  logic [48*WAY_NUM-1:0]  i_req_addr,
   input  logic [64*WAY_NUM-1:0]  i_req_data,
   input  logic [32*WAY_NUM-1:0]  i_req_param,
   input  logic [2*WAY_NUM-1:0]   i_req_type,
   output logic [WAY_NUM-1:0]     o_req_done,
   output logic                   o_exe_valid,
   input  logic                   i_exe_ready,
   output logic [15:0]            o_exe_cmd,
   output logic [15:0]            o_exe_cmd_id,
   output logic [47:0]            o_exe_addr,
   output logic [63:0]            o_exe_data,
   output logic [31:0]            o_exe_param,
   output logic [1:0]             o_exe_type,
   output logic [2:0]             o_exe_way,
   output logic                   o_busy,
   output logic                   o_err,
   output logic [2:0]             o_err_way
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           ptr_q, ptr_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 exe_valid_q, exe_valid_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [2:0]           err_way_q, err_way_d;
   logic [2:0]           exe_way_q, exe_way_d;
   logic [WAY_NUM-1:0]   done_q, done_d;
   logic [WAY_NUM-1:0]   ready_q, ready_d;
   logic [15:0]          exe_cmd_q, exe_cmd_d;
   logic [15:0]          exe_cmd_id_q, exe_cmd_id_d;
   logic [47:0]          exe_addr_q, exe_addr_d;
   logic [63:0]          exe_data_q, exe_data_d;
   logic [31:0]          exe_param_q, exe_param_d;
   logic [1:0]           exe_type_q, exe_type_d;

   logic                 gnt_vld_s;
   logic [2:0]           gnt_idx_s;
   logic                 sel_s;
   logic [15:0]          gnt_cmd_s;
   logic [15:0]          gnt_cmd_id_s;
   logic [47:0]          gnt_addr_s;
   logic [63:0]          gnt_data_s;
   logic [31:0]          gnt_param_s;
   logic [1:0]           gnt_type_s;

   // Round-robin pick: lowest valid way above ptr wins, otherwise lowest valid way at/below ptr
   always_comb begin
      gnt_vld_s    = |i_req_valid;
      gnt_idx_s    = 3'd0;
      sel_s        = 1'b0;
      gnt_cmd_s    = 16'd0;
      gnt_cmd_id_s = 16'd0;
      gnt_addr_s   = 48'd0;
      gnt_data_s   = 64'd0;
      gnt_param_s  = 32'd0;
      gnt_type_s   = 2'd0;
      // Wrapped-around group first so the group after ptr overrides it (last hit wins)
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         gnt_idx_s = (i_req_valid[w] && (int'(ptr_q) >= w)) ? 3'(w) : gnt_idx_s;
      end
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         gnt_idx_s = (i_req_valid[w] && (int'(ptr_q) < w)) ? 3'(w) : gnt_idx_s;
      end
      // One-hot AND-OR payload mux keyed by the chosen index
      for (int w = 0; w < WAY_NUM; w++) begin
         sel_s        = (3'(w) == gnt_idx_s);
         gnt_cmd_s    = gnt_cmd_s    | ({16{sel_s}} & i_req_cmd[w*16 +: 16]);
         gnt_cmd_id_s = gnt_cmd_id_s | ({16{sel_s}} & i_req_cmd_id[w*16 +: 16]);
         gnt_addr_s   = gnt_addr_s   | ({48{sel_s}} & i_req_addr[w*48 +: 48]);
         gnt_data_s   = gnt_data_s   | ({64{sel_s}} & i_req_data[w*64 +: 64]);
         gnt_param_s  = gnt_param_s  | ({32{sel_s}} & i_req_param[w*32 +: 32]);
         gnt_type_s   = gnt_type_s   | ({2{sel_s}}  & i_req_type[w*2 +: 2]);
      end
   end

   // Next-state logic for the IDLE/ISSUE/FIN controller and all registered outputs
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      exe_valid_d  = exe_valid_q;
      err_d        = 1'b0;
      err_way_d    = err_way_q;
      exe_way_d    = exe_way_q;
      done_d       = {WAY_NUM{1'b0}};
      exe_cmd_d    = exe_cmd_q;
      exe_cmd_id_d = exe_cmd_id_q;
      exe_addr_d   = exe_addr_q;
      exe_data_d   = exe_data_q;
      exe_param_d  = exe_param_q;
      exe_type_d   = exe_type_q;

      case (state_q)
         ST_IDLE: begin
            if (gnt_vld_s) begin
               state_d      = ST_ISSUE;
               exe_valid_d  = 1'b1;
               cnt_d        = 16'd0;
               exe_way_d    = gnt_idx_s;
               exe_cmd_d    = gnt_cmd_s;
               exe_cmd_id_d = gnt_cmd_id_s;
               exe_addr_d   = gnt_addr_s;
               exe_data_d   = gnt_data_s;
               exe_param_d  = gnt_param_s;
               exe_type_d   = gnt_type_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!i_exe_ready) begin
               state_d     = ST_FIN;
               exe_valid_d = 1'b0;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               // Executer never accepted: abort without a completion pulse
               state_d     = ST_IDLE;
               exe_valid_d = 1'b0;
               err_d       = 1'b1;
               err_way_d   = exe_way_q;
               ptr_d       = exe_way_q;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_FIN: begin
            if (i_exe_ready) begin
               state_d = ST_IDLE;
               ptr_d   = exe_way_q;
               for (int w = 0; w < WAY_NUM; w++) begin
                  done_d[w] = (3'(w) == exe_way_q);
               end
            end else begin
               state_d = ST_FIN;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            exe_valid_d = 1'b0;
         end
      endcase

      // Prefetch permission only for idle ways while the arbiter will be free next cycle
      for (int w = 0; w < WAY_NUM; w++) begin
         ready_d[w] = (state_d == ST_IDLE) & ~i_req_valid[w];
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge usr_clk) begin
      if (usr_rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= 3'(WAY_NUM - 1);
         cnt_q        <= 16'd0;
         exe_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         err_way_q    <= 3'd0;
         exe_way_q    <= 3'd0;
         done_q       <= {WAY_NUM{1'b0}};
         ready_q      <= {WAY_NUM{1'b0}};
         exe_cmd_q    <= 16'd0;
         exe_cmd_id_q <= 16'd0;
         exe_addr_q   <= 48'd0;
         exe_data_q   <= 64'd0;
         exe_param_q  <= 32'd0;
         exe_type_q   <= 2'd0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         exe_valid_q  <= exe_valid_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         err_way_q    <= err_way_d;
         exe_way_q    <= exe_way_d;
         done_q       <= done_d;
         ready_q      <= ready_d;
         exe_cmd_q    <= exe_cmd_d;
         exe_cmd_id_q <= exe_cmd_id_d;
         exe_addr_q   <= exe_addr_d;
         exe_data_q   <= exe_data_d;
         exe_param_q  <= exe_param_d;
         exe_type_q   <= exe_type_d;
      end
   end

   assign o_req_ready  = ready_q;
   assign o_req_done   = done_q;
   assign o_exe_valid  = exe_valid_q;
   assign o_exe_cmd    = exe_cmd_q;
   assign o_exe_cmd_id = exe_cmd_id_q;
   assign o_exe_addr   = exe_addr_q;
   assign o_exe_data   = exe_data_q;
   assign o_exe_param  = exe_param_q;
   assign o_exe_type   = exe_type_q;
   assign o_exe_way    = exe_way_q;
   assign o_busy       = busy_q;
   assign o_err        = err_q;
   assign o_err_way    = err_way_q;

endmodule

// File: tb/tb_fcc_way_arbiter.sv
// Directed bench for fcc_way_arbiter: cycle table for grant/round-robin/prefetch behaviour,
// hand sequences for timeout and reset during FIN.
module tb_fcc_way_arbiter;
   localparam int WN = 4;
   localparam int TO = 16;

   logic              usr_clk = 1'b0;
   logic              usr_rst;
   logic [WN-1:0]     i_req_valid;
   logic [WN-1:0]     o_req_ready;
   logic [16*WN-1:0]  i_req_cmd;
   logic [16*WN-1:0]  i_req_cmd_id;
   logic [48*WN-1:0]  i_req_addr;
   logic [64*WN-1:0]  i_req_data;
   logic [32*WN-1:0]  i_req_param;
   logic [2*WN-1:0]   i_req_type;
   logic [WN-1:0]     o_req_done;
   logic              o_exe_valid;
   logic              i_exe_ready;
   logic [15:0]       o_exe_cmd;
   logic [15:0]       o_exe_cmd_id;
   logic [47:0]       o_exe_addr;
   logic [63:0]       o_exe_data;
   logic [31:0]       o_exe_param;
   logic [1:0]        o_exe_type;
   logic [2:0]        o_exe_way;
   logic              o_busy;
   logic              o_err;
   logic [2:0]        o_err_way;
   logic [177:0]      act_pay;

   int checks = 0;
   int errors = 0;

   fcc_way_arbiter #(.WAY_NUM(WN), .TIMEOUT(TO)) dut (
      .usr_clk(usr_clk), .usr_rst(usr_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_cmd(i_req_cmd), .i_req_cmd_id(i_req_cmd_id), .i_req_addr(i_req_addr),
      .i_req_data(i_req_data), .i_req_param(i_req_param), .i_req_type(i_req_type),
      .o_req_done(o_req_done), .o_exe_valid(o_exe_valid), .i_exe_ready(i_exe_ready),
      .o_exe_cmd(o_exe_cmd), .o_exe_cmd_id(o_exe_cmd_id), .o_exe_addr(o_exe_addr),
      .o_exe_data(o_exe_data), .o_exe_param(o_exe_param), .o_exe_type(o_exe_type),
      .o_exe_way(o_exe_way), .o_busy(o_busy), .o_err(o_err), .o_err_way(o_err_way)
   );

   assign act_pay = {o_exe_cmd, o_exe_cmd_id, o_exe_addr, o_exe_data, o_exe_param, o_exe_type};

   always #5 usr_clk = ~usr_clk;

   typedef struct {
      logic [3:0] v;
      logic       r;
      int         tag;
      logic       ev;
      logic [2:0] way;
      int         etag;
      logic [3:0] done;
      logic [3:0] rdy;
      logic       busy;
   } vec_t;

   vec_t tbl[36];

   // Payload of way w when the bench drives payload generation t
   function automatic logic [177:0] pay(int w, int t);
      logic [7:0] lo;
      lo = 8'((t << 4) | w);
      return {8'hC3, lo, 8'h1E, lo, 40'hA5_0000_0001, lo, 56'hDE_AD_BE_EF_00_00_00, lo,
              24'hB0_0000, lo, 2'(w ^ t)};
   endfunction

   function automatic vec_t mk(logic [3:0] v, logic r, int tag, logic ev, logic [2:0] way,
                               int etag, logic [3:0] done, logic [3:0] rdy, logic busy);
      vec_t x;
      x.v = v; x.r = r; x.tag = tag; x.ev = ev; x.way = way; x.etag = etag;
      x.done = done; x.rdy = rdy; x.busy = busy;
      return x;
   endfunction

   task automatic drive(input logic [3:0] v, input logic r, input int t);
      logic [177:0] p;
      i_req_valid = v;
      i_exe_ready = r;
      for (int w = 0; w < WN; w++) begin
         p = pay(w, t);
         i_req_cmd[w*16 +: 16]    = p[177:162];
         i_req_cmd_id[w*16 +: 16] = p[161:146];
         i_req_addr[w*48 +: 48]   = p[145:98];
         i_req_data[w*64 +: 64]   = p[97:34];
         i_req_param[w*32 +: 32]  = p[33:2];
         i_req_type[w*2 +: 2]     = p[1:0];
      end
   endtask

   task automatic tick();
      @(posedge usr_clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hcnt;
      logic saw_done;

      // Cycle table; each row = inputs for one edge and outputs expected right after it
      tbl[0]  = mk(4'b1111, 1'b1, 0, 1'b1, 3'd0, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[1]  = mk(4'b1111, 1'b0, 0, 1'b0, 3'd0, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[2]  = mk(4'b1111, 1'b1, 0, 1'b0, 3'd0, 0, 4'b0001, 4'b0000, 1'b0);
      tbl[3]  = mk(4'b1111, 1'b1, 0, 1'b1, 3'd1, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[4]  = mk(4'b1111, 1'b0, 0, 1'b0, 3'd1, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[5]  = mk(4'b1111, 1'b1, 0, 1'b0, 3'd1, 0, 4'b0010, 4'b0000, 1'b0);
      tbl[6]  = mk(4'b1111, 1'b1, 0, 1'b1, 3'd2, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[7]  = mk(4'b1111, 1'b0, 0, 1'b0, 3'd2, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[8]  = mk(4'b1111, 1'b1, 0, 1'b0, 3'd2, 0, 4'b0100, 4'b0000, 1'b0);
      tbl[9]  = mk(4'b1111, 1'b1, 0, 1'b1, 3'd3, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[10] = mk(4'b1111, 1'b0, 0, 1'b0, 3'd3, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[11] = mk(4'b1111, 1'b1, 0, 1'b0, 3'd3, 0, 4'b1000, 4'b0000, 1'b0);
      tbl[12] = mk(4'b1111, 1'b1, 0, 1'b1, 3'd0, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[13] = mk(4'b1111, 1'b0, 0, 1'b0, 3'd0, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[14] = mk(4'b0000, 1'b1, 0, 1'b0, 3'd0, 0, 4'b0001, 4'b1111, 1'b0);
      tbl[15] = mk(4'b0100, 1'b1, 0, 1'b1, 3'd2, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[16] = mk(4'b1011, 1'b1, 1, 1'b1, 3'd2, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[17] = mk(4'b0000, 1'b0, 2, 1'b0, 3'd2, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[18] = mk(4'b0001, 1'b1, 0, 1'b0, 3'd2, 0, 4'b0100, 4'b1110, 1'b0);
      tbl[19] = mk(4'b0001, 1'b1, 3, 1'b1, 3'd0, 3, 4'b0000, 4'b0000, 1'b1);
      tbl[20] = mk(4'b0001, 1'b0, 3, 1'b0, 3'd0, 3, 4'b0000, 4'b0000, 1'b1);
      tbl[21] = mk(4'b0000, 1'b1, 0, 1'b0, 3'd0, 3, 4'b0001, 4'b1111, 1'b0);
      tbl[22] = mk(4'b0010, 1'b1, 0, 1'b1, 3'd1, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[23] = mk(4'b0000, 1'b0, 0, 1'b0, 3'd1, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[24] = mk(4'b0011, 1'b1, 0, 1'b0, 3'd1, 0, 4'b0010, 4'b1100, 1'b0);
      tbl[25] = mk(4'b0011, 1'b1, 0, 1'b1, 3'd0, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[26] = mk(4'b0011, 1'b0, 0, 1'b0, 3'd0, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[27] = mk(4'b0011, 1'b1, 0, 1'b0, 3'd0, 0, 4'b0001, 4'b1100, 1'b0);
      tbl[28] = mk(4'b0011, 1'b1, 0, 1'b1, 3'd1, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[29] = mk(4'b0000, 1'b0, 0, 1'b0, 3'd1, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[30] = mk(4'b0000, 1'b1, 0, 1'b0, 3'd1, 0, 4'b0010, 4'b1111, 1'b0);
      tbl[31] = mk(4'b1000, 1'b1, 0, 1'b1, 3'd3, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[32] = mk(4'b0000, 1'b1, 0, 1'b1, 3'd3, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[33] = mk(4'b0000, 1'b0, 0, 1'b0, 3'd3, 0, 4'b0000, 4'b0000, 1'b1);
      tbl[34] = mk(4'b0000, 1'b1, 0, 1'b0, 3'd3, 0, 4'b1000, 4'b1111, 1'b0);
      tbl[35] = mk(4'b0000, 1'b1, 0, 1'b0, 3'd3, 0, 4'b0000, 4'b1111, 1'b0);

      // Reset with requests pending: reset must win over any grant
      usr_rst = 1'b1;
      drive(4'b1111, 1'b1, 5);
      tick();
      tick();
      check("rst exe_valid", o_exe_valid, 1'b0);
      check("rst busy", o_busy, 1'b0);
      check("rst req_ready", o_req_ready, 4'b0000);
      check("rst req_done", o_req_done, 4'b0000);
      check("rst err", o_err, 1'b0);
      check("rst err_way", o_err_way, 3'd0);
      check("rst exe_way", o_exe_way, 3'd0);
      check("rst payload", act_pay, 178'd0);
      usr_rst = 1'b0;

      for (int i = 0; i < 36; i++) begin
         drive(tbl[i].v, tbl[i].r, tbl[i].tag);
         tick();
         check($sformatf("row%0d exe_valid", i), o_exe_valid, tbl[i].ev);
         check($sformatf("row%0d exe_way", i), o_exe_way, tbl[i].way);
         check($sformatf("row%0d req_done", i), o_req_done, tbl[i].done);
         check($sformatf("row%0d req_ready", i), o_req_ready, tbl[i].rdy);
         check($sformatf("row%0d busy", i), o_busy, tbl[i].busy);
         check($sformatf("row%0d err", i), o_err, 1'b0);
         check($sformatf("row%0d payload", i), act_pay, pay(int'(tbl[i].way), tbl[i].etag));
      end

      // Timeout: ptr is 3, so way 2 is granted; executer never drops ready
      drive(4'b0100, 1'b1, 0);
      tick();
      check("to grant valid", o_exe_valid, 1'b1);
      check("to grant way", o_exe_way, 3'd2);
      hcnt = 1;
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         drive(4'b0000, 1'b1, 0);
         tick();
         if (o_req_done != 4'b0000) saw_done = 1'b1;
         if (o_exe_valid) hcnt++;
         else break;
      end
      check("to valid cycles", hcnt, TO);
      check("to err pulse", o_err, 1'b1);
      check("to err_way", o_err_way, 3'd2);
      check("to busy", o_busy, 1'b0);
      check("to no done", {saw_done, o_req_done}, 5'd0);
      tick();
      check("to err one cycle", o_err, 1'b0);

      // After timeout ptr is 2, so with all ways requesting way 3 goes next
      drive(4'b1111, 1'b1, 0);
      tick();
      check("post-to grant way", o_exe_way, 3'd3);
      check("post-to grant valid", o_exe_valid, 1'b1);
      drive(4'b1111, 1'b0, 0);
      tick();
      check("fin busy", o_busy, 1'b1);

      // Reset while in FIN aborts silently and restores way 0 priority
      usr_rst = 1'b1;
      drive(4'b1111, 1'b0, 0);
      tick();
      check("rst-fin busy", o_busy, 1'b0);
      check("rst-fin exe_valid", o_exe_valid, 1'b0);
      check("rst-fin done", o_req_done, 4'b0000);
      check("rst-fin err", o_err, 1'b0);
      usr_rst = 1'b0;
      drive(4'b1111, 1'b1, 0);
      tick();
      check("rst-fin regrant way", o_exe_way, 3'd0);
      check("rst-fin regrant valid", o_exe_valid, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
